// File: rtl/button_conditioner.sv
// Three-button conditioner: two-flop synchronizers, per-button debounce FSMs, one-cycle press strobes.
// Optional auto-repeat for red and blue is enabled by defining BTN_REPEAT_EN.
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 10000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       red_button_raw,
    input  logic       blue_button_raw,
    input  logic       yellow_button_raw,
    output logic       red_button,
    output logic       blue_button,
    output logic       yellow_button,
    output logic [2:0] press_pulse
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_CYCLES - 1);

`ifdef BTN_REPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW = $clog2(RPT_MAX + 1);
    localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);
`endif

    typedef enum logic [1:0] {
        RELEASED,
        PRESS_WAIT,
        HELD,
        RELEASE_WAIT
    } state_t;

    logic [2:0] raw_bus;
    logic [2:0] clean_bus;
    logic [2:0] pulse_bus;

    assign raw_bus       = {yellow_button_raw, blue_button_raw, red_button_raw};
    assign red_button    = clean_bus[0];
    assign blue_button   = clean_bus[1];
    assign yellow_button = clean_bus[2];
    assign press_pulse   = pulse_bus;

    for (genvar i = 0; i < 3; i++) begin : g_btn
        localparam bit CAN_REPEAT = (i != 2);  // yellow confirms, so it must never repeat

        logic          sync_meta;
        logic          sync_level;
        state_t        state;
        logic [CW-1:0] count;
        logic          level;
        logic          pulse;
`ifdef BTN_REPEAT_EN
        logic [RW-1:0] rpt_count;
        logic          rpt_first;
`endif

        // NOTE: every register here is updated with <=, so each flop samples pre-edge values
        // and the synchronizer really is two stages rather than collapsing into one.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                sync_meta  <= 1'b0;
                sync_level <= 1'b0;
            end else begin
                sync_meta  <= raw_bus[i];
                sync_level <= sync_meta;
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state <= RELEASED;
                count <= '0;
                level <= 1'b0;
                pulse <= 1'b0;
`ifdef BTN_REPEAT_EN
                rpt_count <= '0;
                rpt_first <= 1'b1;
`endif
            end else begin
                pulse <= 1'b0;
                case (state)
                    RELEASED: begin
                        if (sync_level) begin
                            if (DEBOUNCE_CYCLES <= 1) begin
                                state <= HELD;
                                level <= 1'b1;
                                pulse <= 1'b1;
                                count <= '0;
                            end else begin
                                state <= PRESS_WAIT;
                                count <= CW'(1);
                            end
                        end
                    end
                    PRESS_WAIT: begin
                        if (!sync_level) begin
                            state <= RELEASED;
                            count <= '0;
                        end else if (count == DEB_LAST) begin
                            state <= HELD;
                            level <= 1'b1;
                            pulse <= 1'b1;
                            count <= '0;
`ifdef BTN_REPEAT_EN
                            rpt_count <= '0;
                            rpt_first <= 1'b1;
`endif
                        end else begin
                            count <= count + CW'(1);
                        end
                    end
                    HELD: begin
                        if (!sync_level) begin
                            if (DEBOUNCE_CYCLES <= 1) begin
                                state <= RELEASED;
                                level <= 1'b0;
                                count <= '0;
                            end else begin
                                state <= RELEASE_WAIT;
                                count <= CW'(1);
                            end
`ifdef BTN_REPEAT_EN
                            rpt_count <= '0;
                            rpt_first <= 1'b1;
                        end else if (CAN_REPEAT) begin
                            if (rpt_count == (rpt_first ? DELAY_LAST : PERIOD_LAST)) begin
                                pulse     <= 1'b1;
                                rpt_count <= '0;
                                rpt_first <= 1'b0;
                            end else begin
                                rpt_count <= rpt_count + RW'(1);
                            end
`endif
                        end
                    end
                    RELEASE_WAIT: begin
                        if (sync_level) begin
                            state <= HELD;
                            count <= '0;
                        end else if (count == DEB_LAST) begin
                            state <= RELEASED;
                            level <= 1'b0;
                            count <= '0;
                        end else begin
                            count <= count + CW'(1);
                        end
                    end
                    default: begin
                        state <= RELEASED;
                        level <= 1'b0;
                        count <= '0;
                    end
                endcase
            end
        end

        assign clean_bus[i] = level;
        assign pulse_bus[i] = pulse;
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=5.
// Observed vector is {red, blue, yellow, press_pulse[2:0]}; cycle N means N rising edges after the stimulus change.
module tb_button_conditioner;

    logic       clk;
    logic       rst;
    logic       red_button_raw;
    logic       blue_button_raw;
    logic       yellow_button_raw;
    logic       red_button;
    logic       blue_button;
    logic       yellow_button;
    logic [2:0] press_pulse;

    int compared   = 0;
    int mismatched = 0;

    button_conditioner #(
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY   (10),
        .REPEAT_PERIOD  (5)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .red_button_raw   (red_button_raw),
        .blue_button_raw  (blue_button_raw),
        .yellow_button_raw(yellow_button_raw),
        .red_button       (red_button),
        .blue_button      (blue_button),
        .yellow_button    (yellow_button),
        .press_pulse      (press_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [5:0] exp);
        logic [5:0] obs;
        obs = {red_button, blue_button, yellow_button, press_pulse};
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s: observed %b required %b", tag, obs, exp);
        end
    endtask

    // Advance n cycles, checking the expected vector 1 time unit after each rising edge.
    task automatic run(input int n, input logic [5:0] exp, input string tag);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            check(tag, exp);
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst               = 1'b1;
        red_button_raw    = 1'b0;
        blue_button_raw   = 1'b0;
        yellow_button_raw = 1'b0;
        #1;
        check("reset_async", 6'b000_000);
        run(2, 6'b000_000, "reset_hold");
        rst = 1'b0;
        run(3, 6'b000_000, "idle");

        // Red press: level and strobe together at cycle 6
        red_button_raw = 1'b1;
        run(5, 6'b000_000, "red_wait");
        run(1, 6'b100_001, "red_pulse");
        run(3, 6'b100_000, "red_held");

        // Red release with bounce 0,1,0: falls once, 4 cycles after final sync 0
        red_button_raw = 1'b0;
        run(1, 6'b100_000, "bounce_a");
        red_button_raw = 1'b1;
        run(1, 6'b100_000, "bounce_b");
        red_button_raw = 1'b0;
        run(5, 6'b100_000, "bounce_hold");
        run(1, 6'b000_000, "bounce_fall");
        run(3, 6'b000_000, "bounce_after");

        // Blue glitch of 3 cycles never qualifies
        blue_button_raw = 1'b1;
        run(3, 6'b000_000, "glitch_high");
        blue_button_raw = 1'b0;
        run(8, 6'b000_000, "glitch_low");

        // Red and yellow pressed together
        red_button_raw    = 1'b1;
        yellow_button_raw = 1'b1;
        run(5, 6'b000_000, "dual_wait");
        run(1, 6'b101_101, "dual_pulse");
        run(2, 6'b101_000, "dual_held");
        red_button_raw    = 1'b0;
        yellow_button_raw = 1'b0;
        run(5, 6'b101_000, "dual_rel_wait");
        run(2, 6'b000_000, "dual_released");

        // Reset at cycle 4 of a red debounce, raw stays high
        red_button_raw = 1'b1;
        run(4, 6'b000_000, "rst_pre");
        #1;
        rst = 1'b1;
        #1;
        check("rst_mid_async", 6'b000_000);
        run(2, 6'b000_000, "rst_mid_hold");
        rst = 1'b0;
        run(5, 6'b000_000, "rst_redebounce");
        run(1, 6'b100_001, "rst_new_pulse");
        run(1, 6'b100_000, "rst_new_held");
        red_button_raw = 1'b0;
        run(5, 6'b100_000, "rst_rel_wait");
        run(2, 6'b000_000, "rst_released");

        // Blue and yellow held 30 cycles
        blue_button_raw   = 1'b1;
        yellow_button_raw = 1'b1;
        run(5, 6'b000_000, "hold_wait");
        run(1, 6'b011_110, "hold_pulse6");
`ifdef BTN_REPEAT_EN
        run(9, 6'b011_000, "rpt_gap1");
        run(1, 6'b011_010, "rpt_pulse16");
        run(4, 6'b011_000, "rpt_gap2");
        run(1, 6'b011_010, "rpt_pulse21");
        run(4, 6'b011_000, "rpt_gap3");
        run(1, 6'b011_010, "rpt_pulse26");
        run(4, 6'b011_000, "rpt_gap4");
`else
        run(24, 6'b011_000, "no_repeat");
`endif
        blue_button_raw   = 1'b0;
        yellow_button_raw = 1'b0;
        idle(12);
        run(3, 6'b000_000, "final_idle");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, with ports named clk and rst.
REQ-002 Parameter DEBOUNCE_CYCLES, default 500000, SHALL set the number of consecutive stable samples needed to accept a level change (minimum 1).
REQ-003 Parameter REPEAT_DELAY, default 25000000, SHALL set the cycles from accepted press to first auto-repeat pulse (used only under BTN_REPEAT_EN).
REQ-004 Parameter REPEAT_PERIOD, default 10000000, SHALL set the cycles between subsequent auto-repeat pulses (used only under BTN_REPEAT_EN).
REQ-005 The port list SHALL be, one per line, name direction width meaning:
  clk  input  1  system clock
  rst  input  1  asynchronous active-high reset
  red_button_raw  input  1  asynchronous red pushbutton, active-high
  blue_button_raw  input  1  asynchronous blue pushbutton, active-high
  yellow_button_raw  input  1  asynchronous yellow pushbutton, active-high
  red_button  output  1  debounced red level, registered
  blue_button  output  1  debounced blue level, registered
  yellow_button  output  1  debounced yellow level, registered
  press_pulse  output  3  one-cycle press strobes {yellow, blue, red}, registered

Function
REQ-006 Each raw input SHALL pass through a two-flop synchronizer before any other logic.
REQ-007 Each button SHALL have an independent debouncer with its own stable-level register and counter; the counter width SHALL be $clog2(DEBOUNCE_CYCLES+1).
REQ-008 The per-button FSM SHALL have four states: RELEASED, PRESS_WAIT, HELD, RELEASE_WAIT.
REQ-009 In RELEASED, a synchronized 1 SHALL move the FSM to PRESS_WAIT and load the counter with 1.
REQ-010 In PRESS_WAIT, each synchronized 1 SHALL increment the counter; when the counter reaches DEBOUNCE_CYCLES the FSM SHALL move to HELD.
REQ-011 In PRESS_WAIT, any synchronized 0 SHALL return the FSM to RELEASED and clear the counter, with no output change.
REQ-012 RELEASE_WAIT SHALL mirror PRESS_WAIT with inverted polarity, moving from HELD toward RELEASED.
REQ-013 The clean level SHALL be 1 exactly while the FSM is in HELD or RELEASE_WAIT.
REQ-014 A raw level held constant from cycle 0 SHALL appear on the clean output at cycle DEBOUNCE_CYCLES+2.
REQ-015 On the PRESS_WAIT-to-HELD transition, press_pulse[i] SHALL be 1 for exactly one cycle, coincident with the clean level rising.
REQ-016 A release SHALL produce no pulse.
REQ-017 Buttons SHALL be fully independent; simultaneous presses SHALL yield simultaneous pulses on multiple bits.
REQ-018 A clean output SHALL never toggle more than once per DEBOUNCE_CYCLES cycles.

Reset
REQ-019 On rst assertion, the synchronizers, counters and clean outputs SHALL be 0, press_pulse SHALL be 3'b000, and every FSM SHALL be in RELEASED, all immediately and asynchronously.
REQ-020 After a reset that interrupts an in-progress debounce, that debounce SHALL be discarded.
REQ-021 A button held through reset deassertion SHALL be treated as a new press, with its pulse at DEBOUNCE_CYCLES+2 cycles after deassertion.

Configuration
REQ-022 Macro BTN_REPEAT_EN SHALL control auto-repeat, and without the macro there SHALL be no repeat logic or counters.
REQ-023 With BTN_REPEAT_EN defined, while red or blue is in HELD, the block SHALL issue an extra one-cycle press_pulse REPEAT_DELAY cycles after the initial pulse, then every REPEAT_PERIOD cycles.
REQ-024 With BTN_REPEAT_EN defined, leaving HELD SHALL clear the repeat counter.
REQ-025 Yellow (the confirm button) SHALL never auto-repeat.

Verification (DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=5)
REQ-026 Bench SHALL check: red_button_raw 0->1 held at cycle 0 -> red_button=1 and press_pulse=3'b001 for one cycle, both at cycle 6.
REQ-027 Bench SHALL check: blue raw glitches high for 3 cycles then low -> blue_button stays 0 and press_pulse stays 3'b000.
REQ-028 Bench SHALL check: red and yellow raw rise in the same cycle -> press_pulse=3'b101 for one cycle at cycle 6.
REQ-029 Bench SHALL check: rst pulsed at cycle 4 of a red press debounce, raw still high -> outputs 0 during reset, pulse at 6 cycles after deassertion.
REQ-030 Bench SHALL check: with BTN_REPEAT_EN, blue held 30 cycles -> pulses at cycles 6, 16, 21, 26, and yellow held identically -> a single pulse at cycle 6.
REQ-031 Bench SHALL check: held red released with 2-cycle bounce (1,0,1) -> red_button falls exactly once, 4 cycles after the final synchronized 0.
